zsdram_func_module: RTL and testbench

- SDRAM function module that sits directly downstream of the SDRAM control arbiter.
- Consumes the arbiter's one-hot call vector (write/read/refresh/initial) and sequences the SDRAM pin-level commands with timing counters.
- Returns a single-cycle done pulse to the arbiter's iDone input.
- Single-word accesses (burst length 1) with auto-precharge; target is a x16 4-bank SDRAM at about 133 MHz.

---
 rtl/zsdram_pkg.sv | 46 ++++
 rtl/zsdram_func_module.sv | 195 +++++++++++++++++++
 tb/tb_zsdram_func_module.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/zsdram_pkg.sv
// Shared constants for the SDRAM function module: pin commands, call-bit
// indices, FSM states and default timing.
package zsdram_pkg;

   localparam int unsigned CMD_W = 4;
   localparam int unsigned CNT_W = 16;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [CMD_W-1:0] CMD_NOP = 4'b0111;
   localparam logic [CMD_W-1:0] CMD_PRE = 4'b0010;
   localparam logic [CMD_W-1:0] CMD_REF = 4'b0001;
   localparam logic [CMD_W-1:0] CMD_MRS = 4'b0000;
   localparam logic [CMD_W-1:0] CMD_ACT = 4'b0011;
   localparam logic [CMD_W-1:0] CMD_RD  = 4'b0101;
   localparam logic [CMD_W-1:0] CMD_WR  = 4'b0100;

   localparam int unsigned CALL_WR   = 3;
   localparam int unsigned CALL_RD   = 2;
   localparam int unsigned CALL_REF  = 1;
   localparam int unsigned CALL_INIT = 0;

   localparam int unsigned DEF_T_INIT   = 26600;
   localparam int unsigned DEF_T_RP     = 3;
   localparam int unsigned DEF_T_RFC    = 9;
   localparam int unsigned DEF_T_MRD    = 2;
   localparam int unsigned DEF_T_RCD    = 3;
   localparam int unsigned DEF_CAS_LAT  = 3;
   localparam int unsigned DEF_T_WR     = 2;
   localparam int unsigned DEF_MODE_REG = 32'h030;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT_WAIT,
      ST_INIT_PRE,
      ST_INIT_REF1,
      ST_INIT_REF2,
      ST_INIT_MRS,
      ST_REF_WAIT,
      ST_WR_ACT,
      ST_WR_WAIT,
      ST_RD_ACT,
      ST_RD_WAIT,
      ST_DONE
   } state_e;

endpackage

// File: rtl/zsdram_func_module.sv
// Sequences SDRAM init/refresh/single-word write/read commands for one
// arbiter call at a time and returns a one-cycle done pulse.
module zsdram_func_module
   import zsdram_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ROW_W   = 13,
   parameter int unsigned COL_W   = 9,
   parameter int unsigned T_INIT  = DEF_T_INIT,
   parameter int unsigned T_RP    = DEF_T_RP,
   parameter int unsigned T_RFC   = DEF_T_RFC,
   parameter int unsigned T_MRD   = DEF_T_MRD,
   parameter int unsigned T_RCD   = DEF_T_RCD,
   parameter int unsigned CAS_LAT = DEF_CAS_LAT,
   parameter int unsigned T_WR    = DEF_T_WR,
   parameter logic [ROW_W-1:0] MODE_REG = ROW_W'(DEF_MODE_REG)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [3:0]               iCall,
   output logic                     oDone,
   input  logic [2+ROW_W+COL_W-1:0] iAddr,
   input  logic [DATA_W-1:0]        iData,
   output logic [DATA_W-1:0]        oData,
   output logic                     oSDRAM_CKE,
   output logic [CMD_W-1:0]         oSDRAM_CMD,
   output logic [1:0]               oSDRAM_BA,
   output logic [ROW_W-1:0]         oSDRAM_ADDR,
   output logic [1:0]               oSDRAM_DQM,
   inout  wire  [DATA_W-1:0]        ioSDRAM_DQ
);

   localparam int unsigned ADDR_W = 2 + ROW_W + COL_W;
   localparam logic [ROW_W-1:0] A10 = ROW_W'(1024);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CMD_W-1:0]   cmd_q, cmd_d;
   logic [1:0]         ba_q, ba_d;
   logic [ROW_W-1:0]   sa_q, sa_d;
   logic [1:0]         dqm_q, dqm_d;
   logic               done_q, done_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               dq_oe_q, dq_oe_d;
   logic               init_done_q, init_done_d;
   logic [1:0]         bank_q, bank_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;

   logic               fire;

   assign fire = (cnt_q == '0);

   // State, shared wait counter and registered pin outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cmd_q       <= CMD_NOP;
         ba_q        <= '0;
         sa_q        <= '0;
         dqm_q       <= 2'b11;
         done_q      <= 1'b0;
         rdata_q     <= '0;
         dq_oe_q     <= 1'b0;
         init_done_q <= 1'b0;
         bank_q      <= '0;
         col_q       <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         ba_q        <= ba_d;
         sa_q        <= sa_d;
         dqm_q       <= dqm_d;
         done_q      <= done_d;
         rdata_q     <= rdata_d;
         dq_oe_q     <= dq_oe_d;
         init_done_q <= init_done_d;
         bank_q      <= bank_d;
         col_q       <= col_d;
         wdata_q     <= wdata_d;
      end
   end

   // Next-state and next-output logic; a wait loaded with N fires N+1 cycles later
   always_comb begin
      state_d     = state_q;
      cnt_d       = fire ? cnt_q : cnt_q - CNT_W'(1);
      cmd_d       = CMD_NOP;
      ba_d        = '0;
      sa_d        = '0;
      dqm_d       = dqm_q;
      done_d      = 1'b0;
      rdata_d     = rdata_q;
      dq_oe_d     = 1'b0;
      init_done_d = init_done_q;
      bank_d      = bank_q;
      col_d       = col_q;
      wdata_d     = wdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (iCall[CALL_INIT]) begin
               state_d = ST_INIT_WAIT;
               cnt_d   = CNT_W'(T_INIT - 2);
            end else if (init_done_q && iCall[CALL_REF]) begin
               cmd_d   = CMD_REF;
               state_d = ST_REF_WAIT;
               cnt_d   = CNT_W'(T_RFC - 1);
            end else if (init_done_q && (iCall[CALL_WR] || iCall[CALL_RD])) begin
               cmd_d   = CMD_ACT;
               ba_d    = iAddr[ADDR_W-1 -: 2];
               sa_d    = iAddr[COL_W +: ROW_W];
               bank_d  = iAddr[ADDR_W-1 -: 2];
               col_d   = iAddr[COL_W-1:0];
               wdata_d = iData;
               state_d = iCall[CALL_WR] ? ST_WR_ACT : ST_RD_ACT;
               cnt_d   = CNT_W'(T_RCD - 1);
            end
         end
         ST_INIT_WAIT: if (fire) begin
            cmd_d   = CMD_PRE;
            sa_d    = A10;
            state_d = ST_INIT_PRE;
            cnt_d   = CNT_W'(T_RP - 1);
         end
         ST_INIT_PRE: if (fire) begin
            cmd_d   = CMD_REF;
            state_d = ST_INIT_REF1;
            cnt_d   = CNT_W'(T_RFC - 1);
         end
         ST_INIT_REF1: if (fire) begin
            cmd_d   = CMD_REF;
            state_d = ST_INIT_REF2;
            cnt_d   = CNT_W'(T_RFC - 1);
         end
         ST_INIT_REF2: if (fire) begin
            cmd_d   = CMD_MRS;
            sa_d    = MODE_REG;
            state_d = ST_INIT_MRS;
            cnt_d   = CNT_W'(T_MRD - 1);
         end
         ST_INIT_MRS: if (fire) begin
            done_d      = 1'b1;
            init_done_d = 1'b1;
            dqm_d       = 2'b00;
            state_d     = ST_DONE;
         end
         ST_REF_WAIT: if (fire) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         ST_WR_ACT: if (fire) begin
            cmd_d   = CMD_WR;
            ba_d    = bank_q;
            sa_d    = A10 | ROW_W'(col_q);
            dq_oe_d = 1'b1;
            state_d = ST_WR_WAIT;
            cnt_d   = CNT_W'(T_WR + T_RP - 1);
         end
         ST_WR_WAIT: if (fire) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         ST_RD_ACT: if (fire) begin
            cmd_d   = CMD_RD;
            ba_d    = bank_q;
            sa_d    = A10 | ROW_W'(col_q);
            state_d = ST_RD_WAIT;
            cnt_d   = CNT_W'(CAS_LAT);
         end
         // Data lands at the edge ending cycle RD+CAS_LAT
         ST_RD_WAIT: if (fire) begin
            rdata_d = ioSDRAM_DQ;
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         // iCall deliberately ignored here so a registered clear cannot retrigger
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign oDone       = done_q;
   assign oData       = rdata_q;
   assign oSDRAM_CKE  = 1'b1;
   assign oSDRAM_CMD  = cmd_q;
   assign oSDRAM_BA   = ba_q;
   assign oSDRAM_ADDR = sa_q;
   assign oSDRAM_DQM  = dqm_q;
   assign ioSDRAM_DQ  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_zsdram_func_module.sv
// Scoreboard bench: each scenario pushes expected pin events, runs the call,
// then pops and compares against the events the monitor captured.
module tb_zsdram_func_module;
   import zsdram_pkg::*;

   typedef struct packed {
      logic [31:0] cyc;
      logic [3:0]  cmd;
      logic [1:0]  ba;
      logic [12:0] sa;
      logic [15:0] dq;
      logic        done;
      logic [15:0] odata;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  call = 4'b0;
   logic        done;
   logic [23:0] addr = '0;
   logic [15:0] wdata = '0;
   logic [15:0] rdata;
   logic        cke;
   logic [3:0]  cmd;
   logic [1:0]  ba;
   logic [12:0] sa;
   logic [1:0]  dqm;
   wire  [15:0] dq;

   int checks = 0;
   int failures = 0;
   ev_t exp_q[$];
   ev_t obs_q[$];

   // Single-word memory model, CL=3
   logic [15:0] mem_word;
   logic [2:0]  rd_sr;
   logic        mem_oe;

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_sr    <= '0;
         mem_word <= '0;
      end else begin
         rd_sr <= {rd_sr[1:0], (cmd == CMD_RD)};
         if (cmd == CMD_WR) mem_word <= dq;
      end
   end

   assign mem_oe = rd_sr[2];
   assign dq = mem_oe ? mem_word : 16'hzzzz;

   zsdram_func_module dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .iCall       (call),
      .oDone       (done),
      .iAddr       (addr),
      .iData       (wdata),
      .oData       (rdata),
      .oSDRAM_CKE  (cke),
      .oSDRAM_CMD  (cmd),
      .oSDRAM_BA   (ba),
      .oSDRAM_ADDR (sa),
      .oSDRAM_DQM  (dqm),
      .ioSDRAM_DQ  (dq)
   );

   function automatic ev_t mk(input int c, input logic [3:0] k, input logic [1:0] b,
                              input logic [12:0] a, input logic [15:0] d,
                              input logic dn, input logic [15:0] od);
      ev_t e;
      e.cyc = 32'(c); e.cmd = k; e.ba = b; e.sa = a; e.dq = d; e.done = dn; e.odata = od;
      return e;
   endfunction

   function automatic string fmt(input ev_t e);
      return $sformatf("cyc=%0d cmd=%b ba=%0d addr=%h dq=%h done=%b odata=%h",
                       e.cyc, e.cmd, e.ba, e.sa, e.dq, e.done, e.odata);
   endfunction

   function automatic logic [15:0] dq_seen();
      logic [15:0] v;
      v = ((dq === 16'hzzzz) || (dq === 16'h0000)) ? 16'h0000 : dq;
      if (mem_oe && (v === mem_word)) v = 16'h0000;
      return v;
   endfunction

   // Drives a call from a negedge (accept cycle 0) and captures events for n cycles;
   // clears the call one edge after done, like the arbiter's registered clear.
   task automatic run_call(input logic [3:0] c, input logic [23:0] a,
                           input logic [15:0] d, input int n);
      logic clr;
      ev_t  e;
      clr = 1'b0;
      obs_q.delete();
      call = c; addr = a; wdata = d;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         if (clr) begin call = 4'b0; clr = 1'b0; end
         @(negedge clk);
         e = mk(k, cmd, ba, sa, dq_seen(), done, (done === 1'b1) ? rdata : 16'h0);
         if ((cmd !== CMD_NOP) || (done !== 1'b0) || (e.dq !== 16'h0)) obs_q.push_back(e);
         if (done === 1'b1) clr = 1'b1;
      end
   endtask

   task automatic test_reset();
      #12;
      checks++; if (cmd !== CMD_NOP) begin failures++; $display("FAIL reset_cmd got=%b want=%b", cmd, CMD_NOP); end
      checks++; if (cke !== 1'b1) begin failures++; $display("FAIL reset_cke got=%b want=1", cke); end
      checks++; if (ba !== 2'd0) begin failures++; $display("FAIL reset_ba got=%0d want=0", ba); end
      checks++; if (sa !== 13'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", sa); end
      checks++; if (dqm !== 2'b11) begin failures++; $display("FAIL reset_dqm got=%b want=11", dqm); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL reset_odata got=%h want=0", rdata); end
      checks++; if (dq_seen() !== 16'h0) begin failures++; $display("FAIL reset_dq got=%h want=released", dq); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_before_init();
      ev_t e, o;
      run_call(4'b1000, {2'd1, 13'h0ABC, 9'h055}, 16'hA5A5, 1000);
      call = 4'b0;
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL preinit_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL preinit_event got %s want %s", fmt(o), fmt(e)); end
      end
      checks++; if (dqm !== 2'b11) begin failures++; $display("FAIL preinit_dqm got=%b want=11", dqm); end
      checks++; if (cmd !== CMD_NOP) begin failures++; $display("FAIL preinit_cmd got=%b want=%b", cmd, CMD_NOP); end
      exp_q.delete(); obs_q.delete();
      @(negedge clk);
   endtask

   task automatic test_init();
      ev_t e, o;
      exp_q.push_back(mk(26600, CMD_PRE, 2'd0, 13'h0400, 16'h0, 1'b0, 16'h0));
      exp_q.push_back(mk(26603, CMD_REF, 2'd0, 13'h0000, 16'h0, 1'b0, 16'h0));
      exp_q.push_back(mk(26612, CMD_REF, 2'd0, 13'h0000, 16'h0, 1'b0, 16'h0));
      exp_q.push_back(mk(26621, CMD_MRS, 2'd0, 13'h0030, 16'h0, 1'b0, 16'h0));
      exp_q.push_back(mk(26623, CMD_NOP, 2'd0, 13'h0000, 16'h0, 1'b1, 16'h0));
      run_call(4'b0001, '0, '0, 26640);
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL init_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL init_event got %s want %s", fmt(o), fmt(e)); end
      end
      checks++; if (dqm !== 2'b00) begin failures++; $display("FAIL init_dqm got=%b want=00", dqm); end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_write();
      ev_t e, o;
      exp_q.push_back(mk(1, CMD_ACT, 2'd1, 13'h0ABC, 16'h0,    1'b0, 16'h0));
      exp_q.push_back(mk(4, CMD_WR,  2'd1, 13'h0455, 16'hA5A5, 1'b0, 16'h0));
      exp_q.push_back(mk(9, CMD_NOP, 2'd0, 13'h0000, 16'h0,    1'b1, 16'h0));
      run_call(4'b1000, {2'd1, 13'h0ABC, 9'h055}, 16'hA5A5, 15);
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL write_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL write_event got %s want %s", fmt(o), fmt(e)); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_read();
      ev_t e, o;
      exp_q.push_back(mk(1, CMD_ACT, 2'd1, 13'h0ABC, 16'h0, 1'b0, 16'h0));
      exp_q.push_back(mk(4, CMD_RD,  2'd1, 13'h0455, 16'h0, 1'b0, 16'h0));
      exp_q.push_back(mk(8, CMD_NOP, 2'd0, 13'h0000, 16'h0, 1'b1, 16'hA5A5));
      run_call(4'b0100, {2'd1, 13'h0ABC, 9'h055}, 16'h1234, 14);
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL read_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL read_event got %s want %s", fmt(o), fmt(e)); end
      end
      checks++; if (rdata !== 16'hA5A5) begin failures++; $display("FAIL read_hold got=%h want=a5a5", rdata); end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_refresh_priority();
      ev_t e, o;
      exp_q.push_back(mk(1,  CMD_REF, 2'd0, 13'h0000, 16'h0, 1'b0, 16'h0));
      exp_q.push_back(mk(10, CMD_NOP, 2'd0, 13'h0000, 16'h0, 1'b1, 16'hA5A5));
      run_call(4'b0110, {2'd2, 13'h1111, 9'h022}, 16'h5A5A, 25);
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL refresh_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL refresh_event got %s want %s", fmt(o), fmt(e)); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid_write();
      ev_t e, o;
      exp_q.push_back(mk(1, CMD_ACT, 2'd1, 13'h0ABC, 16'h0, 1'b0, 16'h0));
      run_call(4'b1000, {2'd1, 13'h0ABC, 9'h055}, 16'hA5A5, 2);
      rst_n = 1'b0;
      #1;
      checks++; if (cmd !== CMD_NOP) begin failures++; $display("FAIL midrst_cmd got=%b want=%b", cmd, CMD_NOP); end
      checks++; if (dqm !== 2'b11) begin failures++; $display("FAIL midrst_dqm got=%b want=11", dqm); end
      checks++; if (dq_seen() !== 16'h0) begin failures++; $display("FAIL midrst_dq got=%h want=released", dq); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b want=0", done); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL midrst_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL midrst_event got %s want %s", fmt(o), fmt(e)); end
      end
      exp_q.delete(); obs_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_call(4'b1000, {2'd1, 13'h0ABC, 9'h055}, 16'hA5A5, 12);
      call = 4'b0;
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL postrst_write got=%0d events want=0", obs_q.size()); end
      obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_before_init();
      test_init();
      test_write();
      test_read();
      test_refresh_priority();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
